seq_pattern_detector: RTL
=========================

Name: seq_pattern_detector

Overview:
- Sequence-detector datapath driven by the CPU-side stimulus interface: IN_VALID / MODE[1:0] / DATA_IN[3:0].
- In LOAD mode it captures a programmable 4-nibble target pattern.
- In DETECT modes it scans the valid nibble stream for that pattern, overlapping or non-overlapping.
- Reports each hit as a one-cycle pulse and keeps a saturating hit count.

Parameters:
- DATA_W, 4, nibble width of DATA_IN and of each pattern element.
- PAT_LEN, 4, number of elements in the target pattern.
- CNT_W, 8, width of MATCH_CNT.

Ports:
- SYSCLK  input  1  system clock; all state updates on rising edge.
- RST_B  input  1  asynchronous active-low reset.
- IN_VALID  input  1  DATA_IN is sampled on this rising edge when high.
- MODE  input  2  00 IDLE, 01 LOAD, 10 DETECT_NOVL, 11 DETECT_OVL.
- DATA_IN  input  DATA_W  stream nibble / pattern nibble.
- PAT_READY  output  1  high once a complete pattern is loaded.
- OUT_VALID  output  1  one-cycle registered pulse per detected match.
- MATCH_CNT  output  CNT_W  saturating count of matches since the last LOAD entry or reset.
- BUSY  output  1  high while in LOAD with 1..PAT_LEN-1 elements captured.

Behaviour:
- Reset (asynchronous, RST_B=0): state=IDLE; pattern regs, history regs, load_cnt, fill_cnt =0; PAT_READY=0, OUT_VALID=0, MATCH_CNT=0, BUSY=0.
- MODE is sampled every rising edge. A MODE value that differs from the previous cycle's sampled MODE is a mode change; it takes effect on that same edge.
- FSM states: IDLE, LOAD, DET. Transitions:
  - MODE=01 -> LOAD.
  - MODE=1x -> DET.
  - MODE=00 -> IDLE.
- Entering LOAD: PAT_READY:=0, load_cnt:=0, MATCH_CNT:=0, history and fill_cnt cleared.
- LOAD operation:
  - Each edge with IN_VALID=1 stores DATA_IN into pattern[load_cnt] and increments load_cnt.
  - On the PAT_LEN-th store: PAT_READY:=1 (visible next cycle), load_cnt frozen. Further valid nibbles in LOAD are ignored.
- Leaving LOAD with load_cnt<PAT_LEN (aborted load): PAT_READY stays 0, pattern treated as invalid.
- BUSY = (state==LOAD) && load_cnt!=0 && !PAT_READY.
- DET with PAT_READY=0: inputs ignored, OUT_VALID stays 0.
- DET with PAT_READY=1, on each IN_VALID=1 edge:
  - history shifts in DATA_IN; fill_cnt increments, saturating at PAT_LEN.
  - Match condition: fill_cnt (including this nibble) >= PAT_LEN and {last PAT_LEN nibbles, oldest first} == pattern[0..PAT_LEN-1].
  - On a match: OUT_VALID=1 for exactly the following cycle (latency 1 clock from the sampling edge of the last nibble); MATCH_CNT increments, saturating at 2^CNT_W-1.
  - DETECT_NOVL: a match also clears fill_cnt to 0, so the next match needs PAT_LEN fresh nibbles.
  - DETECT_OVL: fill_cnt is kept, so a shared suffix/prefix can match again one nibble later.
- IN_VALID=0 cycles: no shift, no change; gaps do not break a partial sequence.
- Switching between 10 and 11: history and fill_cnt cleared; MATCH_CNT and pattern kept.
- Entering IDLE: history and fill_cnt cleared; pattern, PAT_READY, MATCH_CNT kept.
- Reset asserted mid-operation: immediate return to reset values, including loss of the pattern.

Decomposition:
- Shared package seq_det_pkg:
  - mode constants MODE_IDLE=2'b00, MODE_LOAD=2'b01, MODE_NOVL=2'b10, MODE_OVL=2'b11;
  - FSM state enum;
  - default widths.
- One natural sub-module, seq_window_cmp: history shift register, fill counter and PAT_LEN-wide equality compare. Its inputs are shift_en, clear, nibble, pattern; its output is hit.
- The FSM, load logic and counters stay in the top.

Test Plan:
- Reset then MODE=01, valid nibbles 1,2,3,4 -> PAT_READY=1 the cycle after the 4th edge; BUSY high after nibbles 1-3.
- Pattern 1,2,3,4, MODE=10, stream 0,1,2,3,4,1,2,3,4 -> OUT_VALID pulses 1 cycle after the 5th and 9th valid edges; MATCH_CNT=2.
- Pattern A,A,A,A, stream of six A's:
  - MODE=11 -> 3 pulses, MATCH_CNT=3;
  - same stream in MODE=10 (after reload) -> 1 pulse, MATCH_CNT=1.
- MODE=01 with only 2 valid nibbles, then MODE=10 with stream 1,2,3,4 -> PAT_READY=0, no OUT_VALID, MATCH_CNT=0.
- Pattern 5,6,7,8 in MODE=10, stream 5,6,(IN_VALID=0 for 3 cycles),7,8 -> one match pulse; then RST_B low mid-stream -> all outputs 0 asynchronously.
- Pattern 0,0,0,0 in MODE=11, 300 valid zeros -> MATCH_CNT saturates at 255, OUT_VALID still pulses per match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the sequence pattern detector: mode encodings,
// FSM state codes and default widths.
package seq_det_pkg;

    localparam int DATA_W_DEF  = 4;
    localparam int PAT_LEN_DEF = 4;
    localparam int CNT_W_DEF   = 8;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_NOVL = 2'b10;
    localparam logic [1:0] MODE_OVL  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_LOAD = 2'b01;
    localparam state_t ST_DET  = 2'b10;

endpackage

// File: rtl/seq_pattern_detector_if.sv
// CPU-side stimulus/result bundle of the sequence pattern detector.
interface seq_pattern_detector_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              IN_VALID;
    logic [1:0]        MODE;
    logic [DATA_W-1:0] DATA_IN;
    logic              PAT_READY;
    logic              OUT_VALID;
    logic [CNT_W-1:0]  MATCH_CNT;
    logic              BUSY;

    modport master (
        output IN_VALID, MODE, DATA_IN,
        input  PAT_READY, OUT_VALID, MATCH_CNT, BUSY
    );

    modport slave (
        input  IN_VALID, MODE, DATA_IN,
        output PAT_READY, OUT_VALID, MATCH_CNT, BUSY
    );
endinterface

// File: rtl/seq_window_cmp.sv
// Sliding window over the valid nibble stream: history shift register,
// saturating fill counter and a PAT_LEN-wide compare against the pattern.
// o_hit is combinational for the current edge; the caller registers it.
module seq_window_cmp #(
    parameter int DATA_W  = 4,
    parameter int PAT_LEN = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_shift_en,
    input  logic                           i_clear,
    input  logic                           i_novl,
    input  logic [DATA_W-1:0]              i_nibble,
    input  logic [PAT_LEN-1:0][DATA_W-1:0] i_pattern,
    output logic                           o_hit
);
    localparam int FW = $clog2(PAT_LEN + 1);

    // r_hist[0] is the newest nibble, r_hist[PAT_LEN-1] the oldest
    logic [PAT_LEN-1:0][DATA_W-1:0] r_hist;
    logic [PAT_LEN-1:0][DATA_W-1:0] w_hist_base;
    logic [PAT_LEN-1:0][DATA_W-1:0] w_shift_hist;
    logic [PAT_LEN-1:0][DATA_W-1:0] w_next_hist;
    logic [FW-1:0]                  r_fill;
    logic [FW-1:0]                  w_fill_base;
    logic [FW-1:0]                  w_fill_inc;
    logic [FW-1:0]                  w_next_fill;
    logic                           w_eq;
    logic                           w_hit;

    // Window update: a clear applies first so a nibble arriving on the
    // same edge starts a fresh sequence; the compare sees the shifted window.
    always_comb begin
        w_hist_base = i_clear ? {(PAT_LEN*DATA_W){1'b0}} : r_hist;
        w_fill_base = i_clear ? {FW{1'b0}} : r_fill;
        w_shift_hist[0] = i_nibble;
        for (int i = 1; i < PAT_LEN; i++) begin
            w_shift_hist[i] = w_hist_base[i-1];
        end
        w_fill_inc = (w_fill_base == FW'(PAT_LEN)) ? w_fill_base : (w_fill_base + FW'(1));
        w_eq = 1'b1;
        for (int k = 0; k < PAT_LEN; k++) begin
            w_eq = w_eq & (w_shift_hist[PAT_LEN-1-k] == i_pattern[k]);
        end
        w_hit = i_shift_en && w_eq && (w_fill_inc == FW'(PAT_LEN));
        if (i_shift_en) begin
            w_next_hist = w_shift_hist;
            w_next_fill = (w_hit && i_novl) ? {FW{1'b0}} : w_fill_inc;
        end else begin
            w_next_hist = w_hist_base;
            w_next_fill = w_fill_base;
        end
    end

    // History and fill counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= {(PAT_LEN*DATA_W){1'b0}};
            r_fill <= {FW{1'b0}};
        end else begin
            r_hist <= w_next_hist;
            r_fill <= w_next_fill;
        end
    end

    assign o_hit = w_hit;

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable 4-nibble sequence detector: LOAD captures the target
// pattern, DETECT modes scan the valid stream (overlapping or not),
// each hit gives a one-cycle OUT_VALID pulse and bumps a saturating count.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PAT_LEN = PAT_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic               SYSCLK,
    input logic               RST_B,
    seq_pattern_detector_if.slave bus
);
    localparam int LW = $clog2(PAT_LEN + 1);

    state_t                         r_state;
    logic [1:0]                     r_mode_prev;
    logic [PAT_LEN-1:0][DATA_W-1:0] r_pattern;
    logic [LW-1:0]                  r_load_cnt;
    logic                           r_pat_ready;
    logic                           r_out_valid;
    logic [CNT_W-1:0]               r_match_cnt;
    logic                           r_busy;

    state_t                         w_next_state;
    logic                           w_mode_chg;
    logic                           w_load_entry;
    logic [LW-1:0]                  w_load_base;
    logic                           w_ready_base;
    logic [LW-1:0]                  w_next_load_cnt;
    logic                           w_next_ready;
    logic [PAT_LEN-1:0][DATA_W-1:0] w_next_pattern;
    logic [CNT_W-1:0]               w_cnt_base;
    logic [CNT_W-1:0]               w_next_cnt;
    logic                           w_next_busy;
    logic                           w_shift_en;
    logic                           w_novl;
    logic                           w_hit;

    // Next state follows the sampled MODE directly
    always_comb begin
        case (bus.MODE)
            MODE_IDLE: w_next_state = ST_IDLE;
            MODE_LOAD: w_next_state = ST_LOAD;
            MODE_NOVL: w_next_state = ST_DET;
            MODE_OVL:  w_next_state = ST_DET;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    assign w_mode_chg   = (bus.MODE != r_mode_prev);
    assign w_load_entry = (w_next_state == ST_LOAD) && w_mode_chg;
    assign w_shift_en   = (w_next_state == ST_DET) && r_pat_ready && bus.IN_VALID;
    assign w_novl       = (bus.MODE == MODE_NOVL);

    // Pattern capture: entry restarts the load, a nibble on the entry edge
    // already counts as element 0, nibbles after a full pattern are dropped
    always_comb begin
        w_load_base  = w_load_entry ? {LW{1'b0}} : r_load_cnt;
        w_ready_base = w_load_entry ? 1'b0 : r_pat_ready;
        if ((w_next_state == ST_LOAD) && bus.IN_VALID && !w_ready_base) begin
            for (int k = 0; k < PAT_LEN; k++) begin
                w_next_pattern[k] = (w_load_base == LW'(k)) ? bus.DATA_IN : r_pattern[k];
            end
            w_next_load_cnt = w_load_base + LW'(1);
            w_next_ready    = (w_load_base == LW'(PAT_LEN - 1));
        end else begin
            w_next_pattern  = r_pattern;
            w_next_load_cnt = w_load_base;
            w_next_ready    = w_ready_base;
        end
    end

    // Saturating hit counter, cleared on LOAD entry
    always_comb begin
        w_cnt_base = w_load_entry ? {CNT_W{1'b0}} : r_match_cnt;
        if (w_hit && (w_cnt_base != {CNT_W{1'b1}})) begin
            w_next_cnt = w_cnt_base + CNT_W'(1);
        end else begin
            w_next_cnt = w_cnt_base;
        end
    end

    // BUSY reflects a partially captured pattern after this edge
    always_comb begin
        if ((w_next_state == ST_LOAD) && (w_next_load_cnt != {LW{1'b0}}) && !w_next_ready) begin
            w_next_busy = 1'b1;
        end else begin
            w_next_busy = 1'b0;
        end
    end

    // Any mode change flushes the window; hits only occur in DET
    seq_window_cmp #(
        .DATA_W  (DATA_W),
        .PAT_LEN (PAT_LEN)
    ) u_window (
        .i_clk      (SYSCLK),
        .i_rst_n    (RST_B),
        .i_shift_en (w_shift_en),
        .i_clear    (w_mode_chg),
        .i_novl     (w_novl),
        .i_nibble   (bus.DATA_IN),
        .i_pattern  (r_pattern),
        .o_hit      (w_hit)
    );

    // State, pattern and output registers
    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            r_state     <= ST_IDLE;
            r_mode_prev <= MODE_IDLE;
            r_pattern   <= {(PAT_LEN*DATA_W){1'b0}};
            r_load_cnt  <= {LW{1'b0}};
            r_pat_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_match_cnt <= {CNT_W{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mode_prev <= bus.MODE;
            r_pattern   <= w_next_pattern;
            r_load_cnt  <= w_next_load_cnt;
            r_pat_ready <= w_next_ready;
            r_out_valid <= w_hit;
            r_match_cnt <= w_next_cnt;
            r_busy      <= w_next_busy;
        end
    end

    assign bus.PAT_READY = r_pat_ready;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.MATCH_CNT = r_match_cnt;
    assign bus.BUSY      = r_busy;

endmodule
